mask_splitter: RTL
==================

Name: mask_splitter

Overview:
- Sequential inverse of the P02 bit-mask OR stage: the OR stage combines one-hot flags into one N-bit mask; this block splits an N-bit mask back into its one-hot components.
- Accepts a mask over a valid/ready handshake and emits one one-hot word per output handshake, lowest set bit first, plus the bit index and a last flag.
- The OR of all one-hot words emitted for a mask equals that mask.
- Sits between mask-producing logic and per-lane consumers in P02.

Parameters:
- N, 4, mask width; N >= 2.
- IDX_W, $clog2(N), width of the bit-index output (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  block can accept a mask.
- in_mask  input  N  mask to split.
- out_valid  output  1  out_onehot, out_idx and out_last are valid.
- out_ready  input  1  consumer accepts the current output word.
- out_onehot  output  N  single set bit of the pending mask.
- out_idx  output  IDX_W  index of the bit in out_onehot.
- out_last  output  1  current word is the final one for this mask.
- busy  output  1  a mask is pending (state EMIT).

Behaviour:
- Clock, reset and state:
  - Interface: one clock, clk; reset rst is synchronous, active-high.
  - Registers: state (IDLE/EMIT) and pending[N-1:0]. Everything else is combinational from these registers.
- Reset (including mid-EMIT):
  - Next edge gives state=IDLE and pending=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_onehot=0, out_idx=0, out_last=0, busy=0.
  - A partially emitted mask is discarded; there are no further outputs for it.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid=1 with in_mask!=0: latch pending=in_mask and go to EMIT.
  - in_valid=1 with in_mask==0: the mask is consumed, no output is produced and the state stays IDLE.
- EMIT:
  - in_ready=0, busy=1, out_valid=1.
  - out_onehot = pending & (~pending + 1), i.e. the lowest set bit.
  - out_idx = position of that bit.
  - out_last = 1 when pending has exactly one bit set.
  - On out_valid & out_ready: pending clears the emitted bit.
  - If out_last is set on that handshake, go to IDLE.
- Latency:
  - The first output is valid the cycle after the input handshake.
  - With out_ready held high, a mask with k set bits drains in k cycles; in_ready rises the cycle after the last handshake.
  - Throughput for a full-ones mask: one mask per N+1 cycles.
- Backpressure:
  - While out_ready=0, all outputs hold stable and pending is unchanged.
  - out_valid never drops without a handshake, except on rst.
- Input side:
  - in_mask is sampled only on the input handshake; changes on in_mask during EMIT are ignored.
  - in_valid during EMIT is not accepted; the producer must hold it.
- Boundary masks:
  - All-ones emits N words with idx 0..N-1 in order.
  - MSB-only emits one word with out_idx=N-1 and out_last=1.

Decomposition:
- Pkg_Global:
  - Add the typedef enum logic {IDLE, EMIT} split_state_e.
  - No new constants are needed; IDX_W stays a local derived parameter.
- Sub-module lsb_isolate #(N):
  - Combinational: mask in; onehot, idx, single (popcount==1) out.
  - Instantiated once on pending.
- mask_splitter holds the FSM and pending register: about 150–200 RTL lines total.

Test Plan:
1. Reset mid-operation: N=4, send 4'b1111, take two outputs, assert rst for one cycle → outputs return to reset values; in_ready=1; no further outputs for that mask.
2. Basic split: N=4, in_mask=4'b1011, out_ready=1 → outputs 0001/idx0, 0010/idx1, 1000/idx3 on consecutive cycles starting one cycle after the input handshake; out_last only on the third; in_ready=1 on the following cycle.
3. Zero mask: in_mask=4'b0000 handshaken → out_valid stays 0, in_ready stays 1; the next mask 4'b0100 gives a single word 0100/idx2/last.
4. Backpressure: in_mask=4'b0110, out_ready low for 3 cycles then high → 0010/idx1 held stable for all 3 stall cycles, then 0100/idx2/last.
5. Input ignored while busy: in_valid held with differing in_mask during EMIT → no acceptance until IDLE; the held mask is accepted the cycle after the last output.
6. Scoreboard (N=8): 500 random masks with random out_ready → the OR of emitted one-hots equals the input mask; indices strictly increase within a mask; exactly one out_last per nonzero mask.

Source files
------------

// File: rtl/mask_splitter_pkg.sv
// Shared types for the mask splitter: the two-state sequencing enum.
package mask_splitter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } split_state_e;

endpackage

// File: rtl/mask_splitter_lsb_isolate.sv
// Combinational lowest-set-bit isolator: one-hot of the lowest set bit,
// its index, and a flag for masks holding exactly one set bit.
module lsb_isolate #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  always_comb begin
    onehot = mask & (~mask + N'(1));
    idx    = '0;
    // Scan downward so the last hit is the lowest set bit.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
    single = (mask != '0) && ((mask & (mask - N'(1))) == '0);
  end

endmodule

// File: rtl/mask_splitter.sv
// Splits an N-bit mask into its one-hot components, lowest bit first,
// one word per output handshake.
//
// state | meaning
// IDLE  | ready for a mask; a zero mask is consumed without output
// EMIT  | pending holds the bits still to be emitted
module mask_splitter
  import mask_splitter_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  split_state_e     state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     lsb_onehot;
  logic [IDX_W-1:0] lsb_idx;
  logic             lsb_single;

  lsb_isolate #(.N(N)) u_lsb (
    .mask   (pending_q),
    .onehot (lsb_onehot),
    .idx    (lsb_idx),
    .single (lsb_single)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_onehot = '0;
    out_idx    = '0;
    out_last   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (in_mask != '0)) begin
          pending_d = in_mask;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_onehot = lsb_onehot;
        out_idx    = lsb_idx;
        out_last   = lsb_single;
        if (out_ready) begin
          pending_d = pending_q & ~lsb_onehot;
          if (lsb_single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
